kbd_scan_ctrl: RTL and testbench

- Sequences a Nascom-style keyboard matrix: 8 rows selected by an external counter, 7 column sense lines returned through a hex Schmitt inverter.
- Drives the counter's clock and clear pulses, debounces each row and queues make/break events in a 4-deep FIFO.
- Events are read out over a valid/ready handshake.
- Sits between the keyboard matrix glue chips and the CPU-side port logic.

---
 rtl/kbd_scan_ctrl_if.sv | 39 +++
 rtl/kbd_scan_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_kbd_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// kbd_scan_ctrl_if
// Event read-out bus between the keyboard scan controller and the CPU-side
// port logic.
//
// Signals:
//   evt_valid  head event present (FIFO non-empty)
//   evt_code   head event {brk, 1'b0, row[2:0], col[2:0]}; brk=1 is release
//   evt_ready  consumer takes the head event when evt_valid & evt_ready
//   overflow   sticky flag: an event was dropped because the FIFO was full
//   ovf_clr    clears overflow
//
// Modports:
//   master  the scan controller (produces events)
//   slave   the consumer (accepts events, clears overflow)
// ---------------------------------------------------------------------------
interface kbd_scan_ctrl_if;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ready;
  logic       overflow;
  logic       ovf_clr;

  modport master (
    output evt_valid,
    output evt_code,
    output overflow,
    input  evt_ready,
    input  ovf_clr
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  overflow,
    output evt_ready,
    output ovf_clr
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_scan_ctrl
// Sequences a Nascom-style 8x7 keyboard matrix. An external counter selects
// the row; this block pulses its clock/clear lines, keeps a mirror of its
// value, debounces every row and queues make/break events in a 4-deep FIFO
// that is read out over a valid/ready handshake.
//
// Parameters:
//   SETTLE_CYC  cycles row_sel is held before the columns are sampled (1..255)
//   DEBOUNCE_N  identical consecutive samples needed to accept a change (1..15)
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-high
//   enable       scan enable
//   col[6:0]     column sense, active-high, bit n = column n
//   row_clk      one-cycle pulse advancing the external row counter
//   row_clr      one-cycle pulse clearing the external row counter
//   row_sel[2:0] mirror of the external counter
//   scan_active  high whenever the sequencer is not idle
//   evt          event bus (kbd_scan_ctrl_if.master)
//
// Optional feature (macro KBD_SCAN_IRQ_EN):
//   irq_mask     input, masks the interrupt
//   irq          output, registered (evt_valid | overflow) & ~irq_mask
// ---------------------------------------------------------------------------
module kbd_scan_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DEBOUNCE_N = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] col,
  output logic       row_clk,
  output logic       row_clr,
  output logic [2:0] row_sel,
  output logic       scan_active,
`ifdef KBD_SCAN_IRQ_EN
  input  logic       irq_mask,
  output logic       irq,
`endif
  kbd_scan_ctrl_if.master evt
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    SAMPLE,
    EMIT,
    NEXT
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] DEB_MAX     = 4'(DEBOUNCE_N);

  state_t     state;
  state_t     next_state;

  logic [7:0] settle_cnt;
  logic [2:0] emit_col;

  logic [6:0] stable    [8];
  logic [6:0] candidate [8];
  logic [3:0] cnt       [8];

  logic [7:0] fifo_mem  [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       ovf_flag;

  logic       row_clk_d;
  logic       row_clr_d;
  logic       emit_hit;
  logic [7:0] emit_code;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;
  logic       drop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A dropped enable is only honoured in NEXT so the
  // current row always finishes cleanly.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable) next_state = CLR;
      CLR:     next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  next_state = EMIT;
      EMIT:    if (emit_col == 3'd6) next_state = NEXT;
      NEXT: begin
        if (!enable)               next_state = IDLE;
        else if (row_sel == 3'd7)  next_state = CLR;
        else                       next_state = SETTLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode. row_clk/row_clr are computed from the next state so the
  // registered pulse lines up with the CLR/NEXT cycle itself. The wrapping
  // NEXT (row 7) gives no row_clk; the following CLR resets the counter.
  always_comb begin
    row_clr_d = (next_state == CLR);
    row_clk_d = (next_state == NEXT) && (row_sel != 3'd7);
    emit_hit  = (state == EMIT) && (cnt[row_sel] == DEB_MAX) &&
                (candidate[row_sel][emit_col] != stable[row_sel][emit_col]);
    emit_code = {~candidate[row_sel][emit_col], 1'b0, row_sel, emit_col};
  end

  assign scan_active = (state != IDLE);

  // Sequencer datapath: pulse registers, row mirror, timers and the
  // per-row debounce images.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_clk    <= 1'b0;
      row_clr    <= 1'b0;
      row_sel    <= 3'd0;
      settle_cnt <= 8'd0;
      emit_col   <= 3'd0;
      for (int r = 0; r < 8; r++) begin
        stable[r]    <= 7'd0;
        candidate[r] <= 7'd0;
        cnt[r]       <= 4'd0;
      end
    end else begin
      row_clk <= row_clk_d;
      row_clr <= row_clr_d;

      if (state == CLR) begin
        row_sel <= 3'd0;
      end else if ((state == NEXT) && (row_sel != 3'd7)) begin
        row_sel <= row_sel + 3'd1;
      end

      settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      emit_col   <= (state == EMIT) ? emit_col + 3'd1 : 3'd0;

      // Any change restarts the count; an unchanged sample moves it toward
      // the acceptance threshold, where it saturates.
      if (state == SAMPLE) begin
        if (col != candidate[row_sel]) begin
          candidate[row_sel] <= col;
          cnt[row_sel]       <= 4'd1;
        end else if (cnt[row_sel] != DEB_MAX) begin
          cnt[row_sel] <= cnt[row_sel] + 4'd1;
        end
      end

      // The accepted image follows the candidate even when the event is
      // dropped, so a lost event is never re-reported.
      if (emit_hit) begin
        stable[row_sel][emit_col] <= candidate[row_sel][emit_col];
      end
    end
  end

  assign fifo_full = (fifo_cnt == 3'd4);
  assign pop       = evt.evt_valid & evt.evt_ready;
  assign push_ok   = emit_hit & (~fifo_full | pop);
  assign drop      = emit_hit & fifo_full & ~pop;

  // Event FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= emit_code;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. A drop in the
  // same cycle as ovf_clr leaves overflow set.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      ovf_flag <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      unique case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) begin
        ovf_flag <= 1'b1;
      end else if (evt.ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (fifo_cnt != 3'd0);
  assign evt.evt_code  = evt.evt_valid ? fifo_mem[rd_ptr] : 8'd0;
  assign evt.overflow  = ovf_flag;

`ifdef KBD_SCAN_IRQ_EN
  // Interrupt request, registered from the current FIFO/overflow status.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (evt.evt_valid | ovf_flag) & ~irq_mask;
    end
  end
`endif

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kbd_scan_ctrl
// Self-checking bench for kbd_scan_ctrl with SETTLE_CYC=4, DEBOUNCE_N=3.
// A model of the external row counter drives col from a key matrix image;
// expected events are queued when keys change and compared as they are read.
// ---------------------------------------------------------------------------
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] col;
  logic       row_clk;
  logic       row_clr;
  logic [2:0] row_sel;
  logic       scan_active;
`ifdef KBD_SCAN_IRQ_EN
  logic       irq_mask;
  logic       irq;
`endif

  kbd_scan_ctrl_if bus ();

  kbd_scan_ctrl #(
    .SETTLE_CYC (4),
    .DEBOUNCE_N (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .col         (col),
    .row_clk     (row_clk),
    .row_clr     (row_clr),
    .row_sel     (row_sel),
    .scan_active (scan_active),
`ifdef KBD_SCAN_IRQ_EN
    .irq_mask    (irq_mask),
    .irq         (irq),
`endif
    .evt         (bus.master)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         evt_seen = 0;
  logic [7:0] exp_q [$];
  logic [6:0] keys [8];
  logic [2:0] ext_row = 3'd0;

  // External row counter model; the matrix answers for the row it selects.
  always @(posedge clk) begin
    if (row_clr)      ext_row <= 3'd0;
    else if (row_clk) ext_row <= ext_row + 3'd1;
  end

  assign col = keys[ext_row];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic oclr);
    enable        = en;
    bus.evt_ready = rdy;
    bus.ovf_clr   = oclr;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic waitScanStart();
    logic found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      stepCycles(1);
      if (row_clr) found = 1'b1;
    end
    checkOutput("wait_scan_start", 32'(found), 32'd1);
  endtask

  task automatic waitRow(input logic [2:0] r);
    logic found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      stepCycles(1);
      if (row_sel == r) found = 1'b1;
    end
    checkOutput("wait_row", 32'(found), 32'd1);
  endtask

  // Scoreboard: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.evt_valid && bus.evt_ready) begin
      evt_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("evt_unexpected", 32'(bus.evt_code), 32'h100);
      end else begin
        checkOutput("evt_code", 32'(bus.evt_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int t0;
    int clr_t;
    int clk_t [$];
    int both_hi;
    int valid_hi;
    int seen0;
    int clr_cnt;

    for (int r = 0; r < 8; r++) keys[r] = 7'd0;
`ifdef KBD_SCAN_IRQ_EN
    irq_mask = 1'b0;
`endif
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(3);
    reset = 1'b0;
    stepCycles(1);

    $display("[TB] reset values");
    checkOutput("rst_row_clk", 32'(row_clk), 32'd0);
    checkOutput("rst_row_clr", 32'(row_clr), 32'd0);
    checkOutput("rst_row_sel", 32'(row_sel), 32'd0);
    checkOutput("rst_scan_active", 32'(scan_active), 32'd0);
    checkOutput("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    checkOutput("rst_evt_code", 32'(bus.evt_code), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);

    $display("[TB] idle scan timing");
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("clr_pulse", 32'(row_clr), 32'd1);
    checkOutput("clr_active", 32'(scan_active), 32'd1);
    t0 = cyc;
    clr_t = -1;
    both_hi = 0;
    valid_hi = 0;
    for (int i = 0; i < 150 && clr_t < 0; i++) begin
      stepCycles(1);
      if (row_clk) clk_t.push_back(cyc);
      if (row_clk && row_clr) both_hi++;
      if (bus.evt_valid) valid_hi++;
      if (row_clr) clr_t = cyc;
    end
    checkOutput("row_clk_count", 32'(clk_t.size()), 32'd7);
    if (clk_t.size() > 0) checkOutput("first_row_clk", 32'(clk_t[0] - t0), 32'd13);
    for (int i = 1; i < clk_t.size(); i++) begin
      checkOutput("row_clk_gap", 32'(clk_t[i] - clk_t[i-1]), 32'd13);
    end
    checkOutput("scan_period", 32'(clr_t - t0), 32'd105);
    checkOutput("clk_clr_overlap", 32'(both_hi), 32'd0);
    checkOutput("idle_evt_valid", 32'(valid_hi), 32'd0);
    checkOutput("row_mirror", 32'(row_sel), 32'(ext_row));

    $display("[TB] debounced make/break on row 3 col 2");
    keys[3] = 7'b0000100;
    exp_q.push_back(8'h1A);
    repeat (3) waitScanStart();
    stepCycles(5);
    checkOutput("make_drained", 32'(exp_q.size()), 32'd0);
    keys[3] = 7'b0000000;
    exp_q.push_back(8'h9A);
    repeat (3) waitScanStart();
    stepCycles(5);
    checkOutput("break_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] bouncing key on row 5");
    seen0 = evt_seen;
    for (int s = 0; s < 6; s++) begin
      keys[5][0] = (s % 2 == 0);
      waitScanStart();
    end
    keys[5] = 7'd0;
    repeat (3) waitScanStart();
    checkOutput("bounce_events", 32'(evt_seen - seen0), 32'd0);

    $display("[TB] fifo overflow");
    applyStimulus(1'b1, 1'b0, 1'b0);
    keys[1] = 7'b1010011;
    keys[2] = 7'b0000001;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h0E);
    repeat (3) waitScanStart();
    stepCycles(2);
    checkOutput("ovf_set", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_valid", 32'(bus.evt_valid), 32'd1);
    checkOutput("ovf_head", 32'(bus.evt_code), 32'h08);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ovf_cleared", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(6);
    checkOutput("ovf_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("ovf_empty", 32'(bus.evt_valid), 32'd0);
    keys[1] = 7'd0;
    keys[2] = 7'd0;
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h89);
    exp_q.push_back(8'h8C);
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h90);
    repeat (3) waitScanStart();
    stepCycles(2);
    checkOutput("release_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("release_no_ovf", 32'(bus.overflow), 32'd0);

    $display("[TB] push and pop while full");
    waitScanStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    keys[1] = 7'b1010011;
    keys[3] = 7'b0000001;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'h0E);
    exp_q.push_back(8'h18);
    repeat (2) waitScanStart();
    waitRow(3'd3);
    stepCycles(5);
    checkOutput("full_valid", 32'(bus.evt_valid), 32'd1);
    seen0 = evt_seen;
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(8);
    checkOutput("full_one_pop", 32'(evt_seen - seen0), 32'd1);
    checkOutput("full_no_ovf", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(6);
    checkOutput("full_occupancy", 32'(evt_seen - seen0), 32'd5);
    checkOutput("full_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] enable drop during row 4");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitScanStart();
    waitRow(3'd4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    clr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      stepCycles(1);
      if (row_clr) clr_cnt++;
    end
    checkOutput("stop_no_clr", 32'(clr_cnt), 32'd0);
    checkOutput("stop_idle", 32'(scan_active), 32'd0);
    checkOutput("stop_row_sel", 32'(row_sel), 32'd5);
    checkOutput("stop_mirror", 32'(row_sel), 32'(ext_row));
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("restart_clr", 32'(row_clr), 32'd1);

    $display("[TB] reset during EMIT");
    keys[1] = 7'd0;
    keys[3] = 7'd0;
    repeat (3) waitScanStart();
    checkOutput("pre_rst_valid", 32'(bus.evt_valid), 32'd1);
    checkOutput("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("pre_rst_head", 32'(bus.evt_code), 32'h88);
    waitRow(3'd2);
    stepCycles(7);
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    checkOutput("mid_rst_row_clk", 32'(row_clk), 32'd0);
    checkOutput("mid_rst_row_clr", 32'(row_clr), 32'd0);
    checkOutput("mid_rst_row_sel", 32'(row_sel), 32'd0);
    checkOutput("mid_rst_scan_active", 32'(scan_active), 32'd0);
    checkOutput("mid_rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    checkOutput("mid_rst_evt_code", 32'(bus.evt_code), 32'd0);
    checkOutput("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
